// File: rtl/mem_sdp_if.sv
// mem_sdp_if: request/response bundle for the mem_sdp simple-dual-port RAM.
//   cs       chip select, gates both ports
//   we       write request, with wr_addr / wr_data / wr_be
//   re       read request, with rd_addr
//   rd_data  read data, held between rd_valid pulses
//   rd_valid one-cycle pulse marking rd_data as new
//   busy     power-on clear in progress; requests are ignored
// The master modport is the requester side and the slave modport is the RAM side.
interface mem_sdp_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  logic                  cs;
  logic                  we;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [BE_WIDTH-1:0]   wr_be;
  logic                  re;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  busy;

  modport master (
    output cs, we, wr_addr, wr_data, wr_be, re, rd_addr,
    input  rd_data, rd_valid, busy
  );

  modport slave (
    input  cs, we, wr_addr, wr_data, wr_be, re, rd_addr,
    output rd_data, rd_valid, busy
  );
endinterface

// File: rtl/mem_sdp.sv
// mem_sdp: parametrised simple-dual-port synchronous RAM.
//   clk  rising-edge clock
//   rst  asynchronous, active-high reset; restarts the zero-fill sequence
//   bus  mem_sdp_if.slave: one write port (byte enables) and one read port
//        (1 or 2 cycle latency), both usable in the same cycle.
// After reset the array is zero-filled one word per cycle (busy=1 for DEPTH
// cycles), during which every request is ignored. Reads of addresses at or
// above DEPTH return zero; writes there are dropped. A same-address read and
// write returns either the old word (COLLISION_MODE=0) or the merged new word
// (COLLISION_MODE=1); the write always lands.
module mem_sdp #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 8,
  parameter int DEPTH          = 2**ADDR_WIDTH,
  parameter int RD_LATENCY     = 1,
  parameter int COLLISION_MODE = 0
) (
  input logic       clk,
  input logic       rst,
  mem_sdp_if.slave  bus
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // One extra bit so the range test is a real comparison even when DEPTH
  // fills the whole address space.
  localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(DEPTH - 1);

  typedef enum logic {
    S_CLEAR,
    S_READY
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] clr_cnt_q, clr_cnt_d;
  logic             clr_en;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic             ready;
  logic             wr_in_range, rd_in_range;
  logic             wr_fire, rd_fire;
  logic [IDX_W-1:0] wr_idx, rd_idx;

  logic [DATA_WIDTH-1:0] old_word;
  logic [DATA_WIDTH-1:0] merged_word;
  logic [DATA_WIDTH-1:0] rd_word;

  logic                  rd_valid_q;
  logic [DATA_WIDTH-1:0] rd_data_q;

  // ---------------------------------------------------------------------------
  // Clear sequencer
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    clr_en    = 1'b0;
    case (state_q)
      S_CLEAR: begin
        clr_en    = 1'b1;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == LAST_IDX) begin
          state_d   = S_READY;
          clr_cnt_d = '0;
        end
      end
      S_READY: begin
        state_d = S_READY;
      end
    endcase
  end

  assign ready = (state_q == S_READY);

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  assign wr_in_range = ({1'b0, bus.wr_addr} < DEPTH_EXT);
  assign rd_in_range = ({1'b0, bus.rd_addr} < DEPTH_EXT);

  // Index truncation is only ever used behind the range test, so aliasing of
  // out-of-range addresses onto real rows never reaches the array.
  assign wr_idx = IDX_W'(bus.wr_addr);
  assign rd_idx = IDX_W'(bus.rd_addr);

  assign wr_fire = ready & bus.cs & bus.we & wr_in_range;
  assign rd_fire = ready & bus.cs & bus.re;

  // ---------------------------------------------------------------------------
  // Array
  // ---------------------------------------------------------------------------
  // NOTE: the array has no reset; a reset port would prevent RAM inference.
  // Its contents are defined by the clear sequence instead.
  always_ff @(posedge clk) begin
    if (clr_en) begin
      mem[clr_cnt_q] <= '0;
    end else if (wr_fire) begin
      for (int i = 0; i < NB; i++) begin
        if (bus.wr_be[i]) begin
          mem[wr_idx][8*i +: 8] <= bus.wr_data[8*i +: 8];
        end
      end
    end
  end

  assign old_word = rd_in_range ? mem[rd_idx] : '0;

  // Word as it will look after this cycle's write: used for write-first reads.
  always_comb begin
    merged_word = mem[wr_idx];
    for (int i = 0; i < NB; i++) begin
      if (bus.wr_be[i]) begin
        merged_word[8*i +: 8] = bus.wr_data[8*i +: 8];
      end
    end
  end

  // A collision needs both ports live on the same in-range row; wr_fire
  // already implies the write address is in range.
  always_comb begin
    rd_word = old_word;
    if ((COLLISION_MODE == 1) && wr_fire && (bus.wr_addr == bus.rd_addr)) begin
      rd_word = merged_word;
    end
  end

  // ---------------------------------------------------------------------------
  // Read pipeline
  // ---------------------------------------------------------------------------
  if (RD_LATENCY == 2) begin : g_lat2
    logic                  s1_valid_q;
    logic [DATA_WIDTH-1:0] s1_data_q;

    // Stage 2 drains an accepted read regardless of cs: only rd_fire gates
    // entry into the pipe.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s1_valid_q <= 1'b0;
        s1_data_q  <= '0;
        rd_valid_q <= 1'b0;
        rd_data_q  <= '0;
      end else begin
        s1_valid_q <= rd_fire;
        if (rd_fire) begin
          s1_data_q <= rd_word;
        end
        rd_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          rd_data_q <= s1_data_q;
        end
      end
    end
  end else begin : g_lat1
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd_valid_q <= 1'b0;
        rd_data_q  <= '0;
      end else begin
        rd_valid_q <= rd_fire;
        if (rd_fire) begin
          rd_data_q <= rd_word;
        end
      end
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.busy     = ~ready;

endmodule

// File: doc/mem_sdp.md
Name: mem_sdp

Overview:
Parametrised simple-dual-port synchronous RAM. It is the successor to the team's single-port cs/we/re memory.
- Adds independent write and read ports, usable in the same cycle.
- Adds per-byte write enables and a selectable read latency of 1 or 2 cycles.
- Adds a defined read/write collision policy and a hardware clear sequence that zero-fills the array after reset.
- Sits between datapath producers and consumers as a scratch or line buffer.

Parameters:
- DATA_WIDTH, 8, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 8, address width in bits.
- DEPTH, 2**ADDR_WIDTH, number of words; must satisfy 2 <= DEPTH <= 2**ADDR_WIDTH.
- RD_LATENCY, 1, read latency in cycles; legal values 1 or 2.
- COLLISION_MODE, 0, same-address read+write policy: 0 = read-first (old data), 1 = write-first (new data).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- cs  in  1  chip select; gates both ports
- we  in  1  write request
- wr_addr  in  ADDR_WIDTH  write address
- wr_data  in  DATA_WIDTH  write data
- wr_be  in  DATA_WIDTH/8  byte enables; bit i covers data[8i+7:8i]
- re  in  1  read request
- rd_addr  in  ADDR_WIDTH  read address
- rd_data  out  DATA_WIDTH  read data
- rd_valid  out  1  one-cycle pulse marking rd_data as new
- busy  out  1  clear sequence in progress; all requests ignored

Behaviour:
- Reset (rst=1, async): state=CLEAR, clear counter=0, busy=1, rd_data=0, rd_valid=0, all read pipeline registers and their valid bits = 0. Array contents are not touched asynchronously.
- State CLEAR:
  - each clk edge writes 0 to mem[counter] and increments the counter;
  - on the edge that writes DEPTH-1, go to READY and set busy=0;
  - busy is high for exactly DEPTH cycles after rst deasserts;
  - we/re/cs are ignored and rd_valid stays 0.
- State READY: remains there until rst.
- Write (READY, cs&we, wr_addr<DEPTH): at the edge, for each i with wr_be[i]=1, mem[wr_addr] byte i <= wr_data byte i; other bytes are unchanged. wr_be=0 is a no-op.
- Read (READY, cs&re): request is accepted at edge N.
  - RD_LATENCY=1: rd_data/rd_valid are updated at edge N.
  - RD_LATENCY=2: rd_data/rd_valid are updated at edge N+1.
  - One rd_valid pulse per accepted read; back-to-back reads give a continuous rd_valid with full throughput.
  - rd_data holds its last value when rd_valid=0.
- Out of range (DEPTH < 2**ADDR_WIDTH only):
  - write with wr_addr>=DEPTH is dropped;
  - read with rd_addr>=DEPTH returns 0 with rd_valid=1.
- Collision (cs&we&re, wr_addr==rd_addr, same edge):
  - COLLISION_MODE=0: read returns the pre-write word;
  - COLLISION_MODE=1: read returns the merged word, i.e. enabled bytes from wr_data and remaining bytes from the old word.
  - The write always completes.
- Different addresses in the same cycle: both operations complete independently.
- Reset mid-operation:
  - in-flight reads are discarded, and no rd_valid is produced after rst;
  - a clear in progress restarts from address 0;
  - rst asserted while busy=0 re-runs the full clear.
- cs=0: no array access and no rd_valid; pipeline stage 2 (RD_LATENCY=2) still drains an already-accepted read.

Test Plan:
- DEPTH=16 default-width: release rst at cycle 0 -> busy=1 for cycles 0..15, busy=0 from cycle 16; a read of every address returns 0x00.
- Write 0xA5 to addr 3, then read addr 3 with RD_LATENCY=1 -> rd_data=0xA5 with a single rd_valid pulse one cycle after the request; RD_LATENCY=2 -> same data two cycles after the request.
- DATA_WIDTH=32:
  - write 0x11223344 to addr 5;
  - write 0xAABBCCDD to addr 5 with wr_be=4'b0101;
  - read addr 5 -> 0x11BB33DD.
- Collision on addr 7 holding 0x0F, same-cycle write 0xF0 and read of addr 7:
  - COLLISION_MODE=0 -> read returns 0x0F;
  - COLLISION_MODE=1 -> read returns 0xF0;
  - a subsequent read returns 0xF0 in both modes.
- Requests during busy: write 0x55 to addr 2 and read addr 2 at cycle 4 after reset -> rd_valid never pulses, and after busy=0 a read of addr 2 returns 0x00.
- Streaming and reset:
  - reads of addr 0..9 on consecutive cycles -> 10 consecutive rd_valid pulses with the matching data;
  - rst asserted mid-stream -> rd_valid=0 immediately, rd_data=0, busy=1, and the array reads all-zero after the clear.
